// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI memory arbiter.
//   src_t        : one-bit source index (0 = s0, 1 = s1), also the ID bit
//                  that is prepended on the master side.
//   arb_state_t  : arbiter FSM state.
//   mid_w()      : master-side ID width for a given slave-side ID width.
package axi_arb_pkg;

  typedef logic src_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  function automatic int mid_w(input int id_w);
    return id_w + 1;
  endfunction

endpackage

// File: rtl/axi_rr_grant.sv
// Round-robin grant FSM for one AXI address channel (AW or AR).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_block         : when high, no new grant is made from IDLE
//   i_valid[1:0]    : per-source address valid
//   i_mready        : master-side address ready
//   o_ready[1:0]    : per-source address ready (only the granted source)
//   o_mvalid        : master-side address valid
//   o_grant         : currently granted source (meaningful while granted)
//   o_done          : one-cycle pulse on the master-side handshake
module axi_rr_grant
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_block,
  input  logic [1:0] i_valid,
  input  logic       i_mready,
  output logic [1:0] o_ready,
  output logic       o_mvalid,
  output src_t       o_grant,
  output logic       o_done
);

  arb_state_t r_state;
  src_t       r_rr;
  logic       w_busy;

  assign w_busy     = (r_state == GRANT0) || (r_state == GRANT1);
  assign o_grant    = src_t'(r_state == GRANT1);
  assign o_mvalid   = w_busy && i_valid[o_grant];
  assign o_ready[0] = (r_state == GRANT0) && i_mready;
  assign o_ready[1] = (r_state == GRANT1) && i_mready;
  assign o_done     = o_mvalid && i_mready;

  // A granted source that withdraws valid simply keeps the grant; the
  // FSM only leaves GRANTn on a completed master handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!i_block) begin
            if (&i_valid)        r_state <= r_rr ? GRANT1 : GRANT0;
            else if (i_valid[0]) r_state <= GRANT0;
            else if (i_valid[1]) r_state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (o_done) begin
            r_state <= IDLE;
            r_rr    <= ~o_grant;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-master AXI4 arbiter in front of the single uncore memory port.
// AW and AR are granted round-robin by independent axi_rr_grant instances.
// Write data follows AW grant order via a small source FIFO; B and R are
// routed back by the extra top ID bit the arbiter prepends on the master side.
// Ports:
//   uncoreclk, uncorerst : clock, asynchronous active-high reset
//   s0_* / s1_*          : AXI4 slave ports (AW, W, B, AR, R), ID_W-bit IDs
//   m_*                  : AXI4 master port toward memory, (ID_W+1)-bit IDs
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                      uncoreclk,
  input  logic                      uncorerst,
  // s0
  input  logic [ID_W-1:0]           s0_awid,
  input  logic [ADDR_W-1:0]         s0_awaddr,
  input  logic [7:0]                s0_awlen,
  input  logic [2:0]                s0_awsize,
  input  logic [1:0]                s0_awburst,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_W-1:0]         s0_wdata,
  input  logic [DATA_W/8-1:0]       s0_wstrb,
  input  logic                      s0_wlast,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [ID_W-1:0]           s0_bid,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ID_W-1:0]           s0_arid,
  input  logic [ADDR_W-1:0]         s0_araddr,
  input  logic [7:0]                s0_arlen,
  input  logic [2:0]                s0_arsize,
  input  logic [1:0]                s0_arburst,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [ID_W-1:0]           s0_rid,
  output logic [DATA_W-1:0]         s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rlast,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  // s1
  input  logic [ID_W-1:0]           s1_awid,
  input  logic [ADDR_W-1:0]         s1_awaddr,
  input  logic [7:0]                s1_awlen,
  input  logic [2:0]                s1_awsize,
  input  logic [1:0]                s1_awburst,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_W-1:0]         s1_wdata,
  input  logic [DATA_W/8-1:0]       s1_wstrb,
  input  logic                      s1_wlast,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [ID_W-1:0]           s1_bid,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ID_W-1:0]           s1_arid,
  input  logic [ADDR_W-1:0]         s1_araddr,
  input  logic [7:0]                s1_arlen,
  input  logic [2:0]                s1_arsize,
  input  logic [1:0]                s1_arburst,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [ID_W-1:0]           s1_rid,
  output logic [DATA_W-1:0]         s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rlast,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  // master
  output logic [mid_w(ID_W)-1:0]    m_awid,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [mid_w(ID_W)-1:0]    m_bid,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [mid_w(ID_W)-1:0]    m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [mid_w(ID_W)-1:0]    m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  src_t             w_aw_grant, w_ar_grant, w_head, w_bsel, w_rsel;
  logic             w_aw_done, w_ar_done, w_push, w_pop, w_empty;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  src_t             r_mem [WFIFO_DEPTH];

  // ---------------- address arbitration ----------------
  axi_rr_grant u_aw_grant (
    .clk      (uncoreclk),
    .rst      (uncorerst),
    .i_block  (r_full),
    .i_valid  ({s1_awvalid, s0_awvalid}),
    .i_mready (m_awready),
    .o_ready  ({s1_awready, s0_awready}),
    .o_mvalid (m_awvalid),
    .o_grant  (w_aw_grant),
    .o_done   (w_aw_done)
  );

  axi_rr_grant u_ar_grant (
    .clk      (uncoreclk),
    .rst      (uncorerst),
    .i_block  (1'b0),
    .i_valid  ({s1_arvalid, s0_arvalid}),
    .i_mready (m_arready),
    .o_ready  ({s1_arready, s0_arready}),
    .o_mvalid (m_arvalid),
    .o_grant  (w_ar_grant),
    .o_done   (w_ar_done)
  );

  assign m_awid    = {w_aw_grant, (w_aw_grant ? s1_awid : s0_awid)};
  assign m_awaddr  = w_aw_grant ? s1_awaddr  : s0_awaddr;
  assign m_awlen   = w_aw_grant ? s1_awlen   : s0_awlen;
  assign m_awsize  = w_aw_grant ? s1_awsize  : s0_awsize;
  assign m_awburst = w_aw_grant ? s1_awburst : s0_awburst;

  assign m_arid    = {w_ar_grant, (w_ar_grant ? s1_arid : s0_arid)};
  assign m_araddr  = w_ar_grant ? s1_araddr  : s0_araddr;
  assign m_arlen   = w_ar_grant ? s1_arlen   : s0_arlen;
  assign m_arsize  = w_ar_grant ? s1_arsize  : s0_arsize;
  assign m_arburst = w_ar_grant ? s1_arburst : s0_arburst;

  // ---------------- W-order FIFO ----------------
  // Each granted AW pushes its source; the head source owns the W channel
  // until its wlast beat is accepted. Because entries only exist after an
  // AW grant, W beats can never run ahead of their address.
  assign w_push  = w_aw_done;
  assign w_pop   = m_wvalid && m_wready && m_wlast;
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge uncoreclk or posedge uncorerst) begin
    if (uncorerst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_cnt  <= w_cnt_nxt;
      // Registered so a simultaneous push/pop at full cannot open a grant
      // in the same cycle.
      r_full <= (w_cnt_nxt == CNT_W'(WFIFO_DEPTH));
    end
  end

  // Storage carries no reset: stale entries are never read while empty.
  always_ff @(posedge uncoreclk) begin
    if (w_push) r_mem[r_wptr] <= w_aw_grant;
  end

  // ---------------- W routing ----------------
  assign m_wvalid  = !w_empty && (w_head ? s1_wvalid : s0_wvalid);
  assign m_wdata   = w_head ? s1_wdata : s0_wdata;
  assign m_wstrb   = w_head ? s1_wstrb : s0_wstrb;
  assign m_wlast   = w_head ? s1_wlast : s0_wlast;
  assign s0_wready = !w_empty && !w_head && m_wready;
  assign s1_wready = !w_empty &&  w_head && m_wready;

  // ---------------- B / R routing ----------------
  assign w_bsel    = m_bid[ID_W];
  assign s0_bvalid = m_bvalid && !w_bsel;
  assign s1_bvalid = m_bvalid &&  w_bsel;
  assign m_bready  = w_bsel ? s1_bready : s0_bready;
  assign s0_bid    = m_bid[ID_W-1:0];
  assign s1_bid    = m_bid[ID_W-1:0];
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;

  assign w_rsel    = m_rid[ID_W];
  assign s0_rvalid = m_rvalid && !w_rsel;
  assign s1_rvalid = m_rvalid &&  w_rsel;
  assign m_rready  = w_rsel ? s1_rready : s0_rready;
  assign s0_rid    = m_rid[ID_W-1:0];
  assign s1_rid    = m_rid[ID_W-1:0];
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
module tb_axi_mem_arbiter;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, SW = DATA_W/8;

  logic uncoreclk = 1'b0, uncorerst = 1'b1;
  always #5 uncoreclk = ~uncoreclk;

  logic [ID_W-1:0] s0_awid = '0, s1_awid = '0, s0_arid = '0, s1_arid = '0;
  logic [ADDR_W-1:0] s0_awaddr = '0, s1_awaddr = '0, s0_araddr = '0, s1_araddr = '0;
  logic [7:0] s0_awlen = '0, s1_awlen = '0, s0_arlen = '0, s1_arlen = '0;
  logic [2:0] s0_awsize = 3'd3, s1_awsize = 3'd3, s0_arsize = 3'd3, s1_arsize = 3'd3;
  logic [1:0] s0_awburst = 2'd1, s1_awburst = 2'd1, s0_arburst = 2'd1, s1_arburst = 2'd1;
  logic s0_awvalid = 0, s1_awvalid = 0, s0_arvalid = 0, s1_arvalid = 0;
  logic s0_awready, s1_awready, s0_arready, s1_arready;
  logic [DATA_W-1:0] s0_wdata = '0, s1_wdata = '0;
  logic [SW-1:0] s0_wstrb = '0, s1_wstrb = '0;
  logic s0_wlast = 0, s1_wlast = 0, s0_wvalid = 0, s1_wvalid = 0, s0_wready, s1_wready;
  logic [ID_W-1:0] s0_bid, s1_bid, s0_rid, s1_rid;
  logic [1:0] s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic s0_bvalid, s1_bvalid, s0_bready = 0, s1_bready = 0;
  logic [DATA_W-1:0] s0_rdata, s1_rdata;
  logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready = 0, s1_rready = 0;

  logic [ID_W:0] m_awid, m_arid, m_bid = '0, m_rid = '0;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp = '0, m_rresp = '0;
  logic m_awvalid, m_arvalid, m_awready = 1, m_arready = 1;
  logic [DATA_W-1:0] m_wdata, m_rdata = '0;
  logic [SW-1:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready = 1;
  logic m_bvalid = 0, m_bready, m_rlast = 0, m_rvalid = 0, m_rready;

  axi_mem_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(4)) dut (
    .uncoreclk(uncoreclk), .uncorerst(uncorerst),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awburst(s0_awburst), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
    .s0_wready(s0_wready), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready), .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awburst(s1_awburst), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
    .s1_wready(s1_wready), .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready), .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_chk = 0, n_fail = 0;

  // Scoreboards: address entries are {id5, addr[7:0], len}; W entries are {last, data}.
  logic [31:0] exp_aw[$], exp_ar[$];
  logic [65:0] exp_w[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge uncoreclk); #1;
  endtask

  function automatic logic [31:0] addr_ent(input logic src, input logic [3:0] id, input logic [7:0] len);
    return {11'b0, src, id, 8'(8'h40 + id), len};
  endfunction

  // Monitor: compare every master-side handshake against the scoreboard.
  always @(negedge uncoreclk) begin
    if (!uncorerst) begin
      if (m_awvalid && m_awready)
        check("aw", {11'b0, m_awid, m_awaddr[7:0], m_awlen},
              (exp_aw.size() > 0) ? exp_aw.pop_front() : 32'h8000_0000);
      if (m_arvalid && m_arready)
        check("ar", {11'b0, m_arid, m_araddr[7:0], m_arlen},
              (exp_ar.size() > 0) ? exp_ar.pop_front() : 32'h8000_0000);
      if (m_wvalid && m_wready)
        check("w", {1'b0, m_wlast, m_wdata},
              (exp_w.size() > 0) ? exp_w.pop_front() : {1'b1, 65'h0});
    end
  end

  task automatic aw_send(input int s, input logic [3:0] id, input logic [7:0] len, output int lat);
    bit hs;
    hs = 0; lat = -1;
    if (s == 0) begin s0_awid = id; s0_awaddr = 32'h40 + id; s0_awlen = len; s0_awvalid = 1; end
    else        begin s1_awid = id; s1_awaddr = 32'h40 + id; s1_awlen = len; s1_awvalid = 1; end
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge uncoreclk);
      hs = (s == 0) ? s0_awready : s1_awready;
      if (hs) lat = k;
    end
    tick();
    if (s == 0) s0_awvalid = 0; else s1_awvalid = 0;
    check($sformatf("aw_hs_s%0d", s), hs, 1'b1);
  endtask

  task automatic ar_send(input int s, input logic [3:0] id);
    bit hs;
    hs = 0;
    if (s == 0) begin s0_arid = id; s0_araddr = 32'h40 + id; s0_arlen = 8'd1; s0_arvalid = 1; end
    else        begin s1_arid = id; s1_araddr = 32'h40 + id; s1_arlen = 8'd1; s1_arvalid = 1; end
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge uncoreclk);
      hs = (s == 0) ? s0_arready : s1_arready;
    end
    tick();
    if (s == 0) s0_arvalid = 0; else s1_arvalid = 0;
    check($sformatf("ar_hs_s%0d", s), hs, 1'b1);
  endtask

  task automatic w_beat(input int s, input logic [63:0] d, input logic last);
    bit hs;
    hs = 0;
    if (s == 0) begin s0_wdata = d; s0_wstrb = '1; s0_wlast = last; s0_wvalid = 1; end
    else        begin s1_wdata = d; s1_wstrb = '1; s1_wlast = last; s1_wvalid = 1; end
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge uncoreclk);
      hs = (s == 0) ? s0_wready : s1_wready;
    end
    tick();
    if (s == 0) s0_wvalid = 0; else s1_wvalid = 0;
    check($sformatf("w_hs_s%0d", s), hs, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // ---- reset: outputs quiet even with requests asserted ----
    s0_awvalid = 1; s1_arvalid = 1; s0_wvalid = 1;
    repeat (2) @(posedge uncoreclk);
    @(negedge uncoreclk);
    check("rst_outs", {m_awvalid, m_arvalid, m_wvalid, s0_awready, s1_awready, s0_arready,
                       s1_arready, s0_wready, s1_wready, s0_bvalid, s1_bvalid, s0_rvalid,
                       s1_rvalid}, 13'h0);
    s0_awvalid = 0; s1_arvalid = 0; s0_wvalid = 0;
    tick();
    uncorerst = 0;
    tick();

    // ---- single AW, 4 W beats, B routed to s0 ----
    exp_aw.push_back(addr_ent(1'b0, 4'h3, 8'd3));
    aw_send(0, 4'h3, 8'd3, lat);
    check("aw_latency", lat, 1);
    for (int i = 0; i < 4; i++) begin
      exp_w.push_back({1'b0, (i == 3), 64'hA000 + 64'(i)});
      w_beat(0, 64'hA000 + 64'(i), (i == 3));
    end
    s0_wvalid = 1;                      // FIFO popped: nothing may pass now
    @(negedge uncoreclk);
    check("w_after_last", {m_wvalid, s0_wready}, 2'b00);
    s0_wvalid = 0;
    m_bvalid = 1; m_bid = 5'h03; m_bresp = 2'b10; s0_bready = 1; s1_bready = 0;
    @(negedge uncoreclk);
    check("b_route", {s0_bvalid, s1_bvalid, s0_bid, s0_bresp, m_bready}, {1'b1, 1'b0, 4'h3, 2'b10, 1'b1});
    s0_bready = 0;
    #1 check("b_bready", m_bready, 1'b0);
    tick();
    m_bvalid = 0;

    // ---- AR contention from rr=0: s0, then s1, then s0's second request ----
    exp_ar.push_back(addr_ent(1'b0, 4'h5, 8'd1));
    exp_ar.push_back(addr_ent(1'b1, 4'h9, 8'd1));
    exp_ar.push_back(addr_ent(1'b0, 4'h6, 8'd1));
    fork
      begin ar_send(0, 4'h5); ar_send(0, 4'h6); end
      begin ar_send(1, 4'h9); end
    join
    tick();

    // ---- R interleave with s1 stalled ----
    m_rvalid = 1; m_rid = 5'h12; m_rdata = 64'h1111; m_rlast = 1'b0; s1_rready = 0; s0_rready = 1;
    @(negedge uncoreclk);
    check("r_s1_stall", {s1_rvalid, s0_rvalid, m_rready, s1_rid, s1_rdata[15:0]},
          {1'b1, 1'b0, 1'b0, 4'h2, 16'h1111});
    tick();
    m_rid = 5'h02; m_rdata = 64'h2222; m_rlast = 1'b1;
    @(negedge uncoreclk);
    check("r_s0", {s0_rvalid, s1_rvalid, m_rready, s0_rid, s0_rdata[15:0], s0_rlast},
          {1'b1, 1'b0, 1'b1, 4'h2, 16'h2222, 1'b1});
    tick();
    m_rvalid = 0;

    // ---- W ordering: s1 AW before s0 AW, s0 offers W first ----
    exp_aw.push_back(addr_ent(1'b1, 4'h1, 8'd1));
    exp_aw.push_back(addr_ent(1'b0, 4'h2, 8'd0));
    aw_send(1, 4'h1, 8'd1, lat);
    aw_send(0, 4'h2, 8'd0, lat);
    exp_w.push_back({2'b00, 64'hB0});
    exp_w.push_back({2'b01, 64'hB1});
    exp_w.push_back({2'b01, 64'hC0});
    fork
      w_beat(0, 64'hC0, 1'b1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge uncoreclk);
          check("w_order_hold", {s0_wready, m_wvalid}, 2'b00);
          tick();
        end
        w_beat(1, 64'hB0, 1'b0);
        w_beat(1, 64'hB1, 1'b1);
      end
    join
    tick();

    // ---- FIFO full: 4 AWs granted, W held off, 5th waits ----
    for (int i = 4; i < 8; i++) begin
      exp_aw.push_back(addr_ent(1'b0, 4'(i), 8'd0));
      aw_send(0, 4'(i), 8'd0, lat);
    end
    exp_aw.push_back(addr_ent(1'b1, 4'h8, 8'd0));
    s1_awid = 4'h8; s1_awaddr = 32'h48; s1_awlen = 8'd0; s1_awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge uncoreclk);
      check("aw_full_block", {m_awvalid, s1_awready}, 2'b00);
      tick();
    end
    exp_w.push_back({2'b01, 64'hD0});
    w_beat(0, 64'hD0, 1'b1);            // pop happened on the previous edge
    @(negedge uncoreclk);
    check("aw_full_lat1", m_awvalid, 1'b0);
    tick();
    @(negedge uncoreclk);
    check("aw_full_lat2", {m_awvalid, m_awid}, {1'b1, 5'h18});
    tick();
    s1_awvalid = 0;

    // ---- async reset during W beat 2 of 4 ----
    exp_w.push_back({2'b00, 64'hE1});
    w_beat(0, 64'hE1, 1'b0);
    m_wready = 0;
    s0_wdata = 64'hE2; s0_wlast = 0; s0_wvalid = 1;
    s1_arvalid = 1;
    @(negedge uncoreclk);
    check("rst_pre_wvalid", m_wvalid, 1'b1);
    #2;
    uncorerst = 1; m_wready = 1;
    #1;
    check("rst_async_outs", {m_awvalid, m_arvalid, m_wvalid, s0_awready, s1_awready,
                             s0_arready, s1_arready, s0_wready, s1_wready}, 9'h0);
    s1_arvalid = 0;
    repeat (2) tick();
    uncorerst = 0;
    @(negedge uncoreclk);
    check("rst_fifo_empty", {m_wvalid, s0_wready}, 2'b00);
    tick();
    s0_wvalid = 0;
    exp_aw.push_back(addr_ent(1'b0, 4'hA, 8'd0));
    aw_send(0, 4'hA, 8'd0, lat);
    check("aw_latency_post_rst", lat, 1);
    exp_w.push_back({2'b01, 64'hF0});
    w_beat(0, 64'hF0, 1'b1);
    repeat (2) tick();

    check("aw_sb_drained", exp_aw.size(), 0);
    check("ar_sb_drained", exp_ar.size(), 0);
    check("w_sb_drained", exp_w.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
